// File: rtl/seg7_scan_driver_if.sv
// Display-side bundle of the seven-segment scanner: value/dp/blanking
// requests in, segment, anode and frame-wrap signals out.
interface seg7_scan_driver_if #(
   parameter int DIGITS = 4
);
   logic [4*DIGITS-1:0] num;
   logic [DIGITS-1:0]   dp_in;
   logic                blank_lz;
   logic [6:0]          segs;
   logic                dp;
   logic [DIGITS-1:0]   pos;
   logic                frame_done;

   modport master (
      output num,
      output dp_in,
      output blank_lz,
      input  segs,
      input  dp,
      input  pos,
      input  frame_done
   );

   modport slave (
      input  num,
      input  dp_in,
      input  blank_lz,
      output segs,
      output dp,
      output pos,
      output frame_done
   );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit hex seven-segment scanner with per-frame
// snapshot, leading-zero blanking and anode guard interval.
module seg7_scan_driver #(
   parameter int DIGITS     = 4,
   parameter int REFRESH    = 256,
   parameter int GUARD      = 0,
   parameter bit SEG_ACT_LO = 1'b1,
   parameter bit AN_ACT_LO  = 1'b1
) (
   input logic clk,
   input logic rst,
   seg7_scan_driver_if.slave bus
);

   localparam int CW = $clog2(REFRESH);
   localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam int NW = 4 * DIGITS;

   localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);
   localparam logic [CW:0]   GUARD_W  = (CW+1)'(GUARD);

   localparam logic [DIGITS-1:0] AN_OFF =
      AN_ACT_LO ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
   localparam logic [DIGITS-1:0] AN_D0 =
      AN_ACT_LO ? ~DIGITS'(1) : DIGITS'(1);
   localparam logic [6:0] SEG_ZERO =
      SEG_ACT_LO ? ~7'h3F : 7'h3F;
   localparam logic DP_OFF = SEG_ACT_LO;

   function automatic logic [6:0] glyph(input logic [3:0] v);
      logic [6:0] g;
      unique case (v)
         4'h0: g = 7'h3F;
         4'h1: g = 7'h06;
         4'h2: g = 7'h5B;
         4'h3: g = 7'h4F;
         4'h4: g = 7'h66;
         4'h5: g = 7'h6D;
         4'h6: g = 7'h7D;
         4'h7: g = 7'h07;
         4'h8: g = 7'h7F;
         4'h9: g = 7'h6F;
         4'hA: g = 7'h77;
         4'hB: g = 7'h7C;
         4'hC: g = 7'h39;
         4'hD: g = 7'h5E;
         4'hE: g = 7'h79;
         4'hF: g = 7'h71;
      endcase
      return g;
   endfunction

   logic [CW-1:0]     cnt, cnt_n;
   logic [IW-1:0]     idx, idx_n;
   logic [NW-1:0]     snap_num, num_n;
   logic [DIGITS-1:0] snap_dp, dpv_n;
   logic              snap_lz, lz_n;
   logic              armed, armed_n;

   logic [6:0]        segs_q, segs_n;
   logic              dp_q, dp_n;
   logic [DIGITS-1:0] pos_q, pos_n;
   logic              fd_q;

   logic              slot_end;
   logic              wrap;
   logic [NW-1:0]     shifted;
   logic [3:0]        nib;
   logic              blank;
   logic [CW:0]       gcnt;
   logic              in_guard;
   logic              dp_on;
   logic [DIGITS-1:0] onehot;

   // Next-state view: outputs are computed from the values that will
   // hold after this edge, so digit 0 of a new frame uses the fresh snapshot.
   always_comb begin
      slot_end = (cnt == CNT_LAST);
      wrap     = slot_end && (idx == IDX_LAST);

      cnt_n = slot_end ? '0 : cnt + 1'b1;
      idx_n = idx;
      if (slot_end)
         idx_n = (idx == IDX_LAST) ? '0 : idx + 1'b1;

      num_n   = wrap ? bus.num      : snap_num;
      dpv_n   = wrap ? bus.dp_in    : snap_dp;
      lz_n    = wrap ? bus.blank_lz : snap_lz;
      armed_n = armed | wrap;

      shifted = num_n >> {idx_n, 2'b00};
      nib     = shifted[3:0];
      blank   = lz_n && (idx_n != '0) && (shifted == '0);

      // Guard only starts once the first post-reset frame has wrapped.
      gcnt     = {1'b0, cnt_n} + (CW+1)'(1);
      in_guard = armed_n && (gcnt <= GUARD_W);

      dp_on  = dpv_n[idx_n] && !blank;
      onehot = DIGITS'(1) << idx_n;

      pos_n = AN_ACT_LO ? ~onehot : onehot;
      if (blank || in_guard)
         pos_n = AN_OFF;

      segs_n = SEG_ACT_LO ? ~glyph(nib) : glyph(nib);
      dp_n   = SEG_ACT_LO ? ~dp_on : dp_on;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         idx      <= '0;
         snap_num <= '0;
         snap_dp  <= '0;
         snap_lz  <= 1'b0;
         armed    <= 1'b0;
         segs_q   <= SEG_ZERO;
         dp_q     <= DP_OFF;
         pos_q    <= AN_D0;
         fd_q     <= 1'b0;
      end else begin
         cnt      <= cnt_n;
         idx      <= idx_n;
         snap_num <= num_n;
         snap_dp  <= dpv_n;
         snap_lz  <= lz_n;
         armed    <= armed_n;
         segs_q   <= segs_n;
         dp_q     <= dp_n;
         pos_q    <= pos_n;
         fd_q     <= wrap;
      end
   end

   assign bus.segs       = segs_q;
   assign bus.dp         = dp_q;
   assign bus.pos        = pos_q;
   assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: per-cycle expectations are
// queued by the stimulus and checked by an independent monitor.
module tb_seg7_scan_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;

   seg7_scan_driver_if #(.DIGITS(4)) bus ();

   seg7_scan_driver #(
      .DIGITS(4),
      .REFRESH(4),
      .GUARD(1),
      .SEG_ACT_LO(1'b1),
      .AN_ACT_LO(1'b1)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      tag;
      logic [6:0] s;
      logic       d;
      logic [3:0] p;
      logic       f;
   } exp_t;

   exp_t q[$];
   int checks = 0;
   int failures = 0;
   int cur = 0;

   logic [3:0] one_lo [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   task automatic chk(input string tag, input exp_t e);
      checks++;
      if (bus.segs !== e.s || bus.dp !== e.d ||
          bus.pos !== e.p || bus.frame_done !== e.f) begin
         failures++;
         $display("FAIL %s: got segs=%h dp=%b pos=%b fd=%b want segs=%h dp=%b pos=%b fd=%b",
                  tag, bus.segs, bus.dp, bus.pos, bus.frame_done,
                  e.s, e.d, e.p, e.f);
      end
   endtask

   function automatic exp_t rst_exp(input string tag);
      exp_t e;
      e.tag = tag;
      e.s = 7'h40;
      e.d = 1'b1;
      e.p = 4'b1110;
      e.f = 1'b0;
      return e;
   endfunction

   // sv packs the active-low glyphs {d3,d2,d1,d0}; dv is the dp pin per digit
   task automatic push_frame(input string tag, input logic [27:0] sv,
                             input logic [3:0] dv, input logic [3:0] lit,
                             input bit guard, input bit fd,
                             input int from, input int to);
      exp_t e;
      for (int d = 0; d < 4; d++)
         for (int c = 0; c < 4; c++) begin
            int k;
            k = d * 4 + c;
            if (k >= from && k <= to) begin
               e.tag = $sformatf("%s_d%0d_c%0d", tag, d, c);
               e.s = sv[7*d +: 7];
               e.d = dv[d];
               e.p = (lit[d] && !(guard && c == 0)) ? one_lo[d] : 4'b1111;
               e.f = fd && (k == 0);
               q.push_back(e);
            end
         end
   endtask

   task automatic go_to(input int c);
      repeat (c - cur) @(negedge clk);
      cur = c;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk(e.tag, e);
         end
      end
   end

   localparam logic [27:0] Z4 = {7'h40, 7'h40, 7'h40, 7'h40};
   localparam logic [27:0] V1234 = {7'h79, 7'h24, 7'h30, 7'h19};
   localparam logic [27:0] V00A0 = {7'h40, 7'h40, 7'h08, 7'h40};
   localparam logic [27:0] V1111 = {7'h79, 7'h79, 7'h79, 7'h79};
   localparam logic [27:0] V2222 = {7'h24, 7'h24, 7'h24, 7'h24};

   initial begin
      bus.num = 16'h1234;
      bus.dp_in = 4'b0000;
      bus.blank_lz = 1'b0;

      @(negedge clk);
      q.push_back(rst_exp("reset"));
      @(negedge clk);
      rst = 1'b0;
      cur = 0;
      push_frame("f0_zero", Z4, 4'b1111, 4'b1111, 0, 0, 1, 15);
      push_frame("f1_1234", V1234, 4'b1111, 4'b1111, 1, 1, 0, 15);
      push_frame("f2_lz", V00A0, 4'b1111, 4'b0011, 1, 1, 0, 15);
      push_frame("f3_nolz", V00A0, 4'b1111, 4'b1111, 1, 1, 0, 15);
      push_frame("f4_zero_dp", Z4, 4'b1110, 4'b0001, 1, 1, 0, 15);
      push_frame("f5_1111", V1111, 4'b1111, 4'b1111, 1, 1, 0, 15);
      push_frame("f6_2222", V2222, 4'b1111, 4'b1111, 1, 1, 0, 15);
      push_frame("f7_pre_rst", V2222, 4'b1111, 4'b1111, 1, 1, 0, 9);

      go_to(20);
      bus.num = 16'h00A0;
      bus.blank_lz = 1'b1;
      go_to(36);
      bus.blank_lz = 1'b0;
      go_to(52);
      bus.num = 16'h0000;
      bus.blank_lz = 1'b1;
      bus.dp_in = 4'b1111;
      go_to(68);
      bus.num = 16'h1111;
      bus.blank_lz = 1'b0;
      bus.dp_in = 4'b0000;
      go_to(85);
      bus.num = 16'h2222;

      go_to(121);
      rst = 1'b1;
      #1;
      chk("async_rst_now", rst_exp("async_rst_now"));
      q.push_back(rst_exp("rst_held"));
      @(negedge clk);
      rst = 1'b0;
      cur = 0;
      push_frame("r0_zero", Z4, 4'b1111, 4'b1111, 0, 0, 1, 15);
      push_frame("r1_2222", V2222, 4'b1111, 4'b1111, 1, 1, 0, 15);

      for (int i = 0; i < 100 && q.size() > 0; i++)
         @(posedge clk);
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expectations left, want 0", q.size());
      end
      #2;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
